slp_weight_updater: RTL

Sequential multi-lane weight-update engine for the single-layer perceptron; the multi-lane, stateful successor to the per-weight combinational delta calculation. It owns a register file of N_IN signed weights and, on each accepted training request, applies new_w = sat(w + round(in·rate·error)) to every weight, LANES weights per cycle. It reports completion with sticky overflow, underflow and rounding flags. It sits between the perceptron error stage and the forward-path weight read port.

---
 rtl/slp_weight_updater_pkg.sv | 13 +
 rtl/slp_upd_lane.sv | 70 +++++++
 rtl/slp_weight_updater.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/slp_weight_updater_pkg.sv
// Shared types for the perceptron weight-update engine.
package slp_weight_updater_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } slp_upd_state_t;

    // Only round-half-up exists today; other codes are kept free for later modes.
    localparam int RND_HALF_UP = 0;

endpackage

// File: rtl/slp_upd_lane.sv
// One update lane: w + round(in*rate*error) with saturation and per-lane flags.
module slp_upd_lane
    import slp_weight_updater_pkg::*;
#(
    parameter int I_PREC     = 16,
    parameter int R_PREC     = 16,
    parameter int P_PREC     = 16,
    parameter int W_PREC     = 16,
    parameter int FRAC       = 8,
    parameter int ROUND_MODE = RND_HALF_UP
) (
    input  logic [I_PREC-1:0] in_i,
    input  logic [R_PREC-1:0] rate_i,
    input  logic [P_PREC-1:0] error_i,
    input  logic [W_PREC-1:0] w_i,
    output logic [W_PREC-1:0] w_o,
    output logic              ovf_o,
    output logic              udf_o,
    output logic              rounded_o
);

    localparam int PW = I_PREC + R_PREC + P_PREC;
    localparam int SW = PW + 2;
    localparam int SH = 2 * FRAC;

    localparam logic signed [SW-1:0] W_MAX = {{(SW-W_PREC+1){1'b0}}, {(W_PREC-1){1'b1}}};
    localparam logic signed [SW-1:0] W_MIN = {{(SW-W_PREC+1){1'b1}}, {(W_PREC-1){1'b0}}};

    logic signed [PW-1:0] in_x;
    logic signed [PW-1:0] rate_x;
    logic signed [PW-1:0] err_x;
    logic signed [PW-1:0] prod;
    logic signed [PW:0]   delta;
    logic signed [SW-1:0] sum;

    // The full product of three operands always fits in PW bits.
    assign in_x   = {{(PW-I_PREC){in_i[I_PREC-1]}}, in_i};
    assign rate_x = {{(PW-R_PREC){rate_i[R_PREC-1]}}, rate_i};
    assign err_x  = {{(PW-P_PREC){error_i[P_PREC-1]}}, error_i};
    assign prod   = in_x * rate_x * err_x;

    if (FRAC > 0) begin : g_round
        localparam logic [PW:0] ONE  = {{PW{1'b0}}, 1'b1};
        localparam logic [PW:0] HALF = (ROUND_MODE == RND_HALF_UP) ? (ONE << (SH - 1)) : '0;
        logic signed [PW:0] biased;

        assign biased    = {prod[PW-1], prod} + HALF;
        assign delta     = biased >>> SH;
        assign rounded_o = |prod[SH-1:0];
    end else begin : g_int
        assign delta     = {prod[PW-1], prod};
        assign rounded_o = 1'b0;
    end

    assign udf_o = (prod != '0) && (delta == '0);
    assign sum   = {{(SW-W_PREC){w_i[W_PREC-1]}}, w_i} + {delta[PW], delta};

    always_comb begin
        ovf_o = 1'b0;
        w_o   = sum[W_PREC-1:0];
        if (sum > W_MAX) begin
            ovf_o = 1'b1;
            w_o   = W_MAX[W_PREC-1:0];
        end else if (sum < W_MIN) begin
            ovf_o = 1'b1;
            w_o   = W_MIN[W_PREC-1:0];
        end
    end

endmodule

// File: rtl/slp_weight_updater.sv
// Weight register file plus sequencer that applies one training update, LANES weights per cycle.
//   state | meaning
//   IDLE  | ready; host writes allowed; accept latches operands
//   RUN   | update group idx..idx+LANES-1 each cycle
//   DONE  | one-cycle completion pulse, flags valid
module slp_weight_updater
    import slp_weight_updater_pkg::*;
#(
    parameter int N_IN   = 8,
    parameter int LANES  = 2,
    parameter int I_PREC = 16,
    parameter int R_PREC = 16,
    parameter int P_PREC = 16,
    parameter int W_PREC = 16,
    parameter int FRAC   = 8
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [N_IN*I_PREC-1:0]   req_in,
    input  logic [R_PREC-1:0]        req_rate,
    input  logic [P_PREC-1:0]        req_error,
    input  logic                     wr_en,
    input  logic [$clog2(N_IN)-1:0]  wr_addr,
    input  logic [W_PREC-1:0]        wr_data,
    input  logic [$clog2(N_IN)-1:0]  rd_addr,
    output logic [W_PREC-1:0]        rd_data,
    output logic                     done,
    output logic                     ovf,
    output logic                     udf,
    output logic                     rounded
);

    localparam int AW = $clog2(N_IN);

    if ((N_IN % LANES) != 0) begin : g_bad_cfg
        $error("slp_weight_updater: N_IN must be a multiple of LANES");
    end

    slp_upd_state_t state_q, state_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [N_IN*I_PREC-1:0] in_q, in_d;
    logic [R_PREC-1:0]      rate_q, rate_d;
    logic [P_PREC-1:0]      err_q, err_d;
    logic [W_PREC-1:0]      w_q [N_IN];
    logic [W_PREC-1:0]      w_d [N_IN];
    logic                   ovf_q, ovf_d;
    logic                   udf_q, udf_d;
    logic                   rnd_q, rnd_d;

    logic [AW-1:0]          lane_addr [LANES];
    logic [W_PREC-1:0]      lane_w    [LANES];
    logic [LANES-1:0]       lane_ovf;
    logic [LANES-1:0]       lane_udf;
    logic [LANES-1:0]       lane_rnd;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_addr[l] = idx_q + AW'(l);

        slp_upd_lane #(
            .I_PREC (I_PREC),
            .R_PREC (R_PREC),
            .P_PREC (P_PREC),
            .W_PREC (W_PREC),
            .FRAC   (FRAC)
        ) u_lane (
            .in_i      (in_q[lane_addr[l]*I_PREC +: I_PREC]),
            .rate_i    (rate_q),
            .error_i   (err_q),
            .w_i       (w_q[lane_addr[l]]),
            .w_o       (lane_w[l]),
            .ovf_o     (lane_ovf[l]),
            .udf_o     (lane_udf[l]),
            .rounded_o (lane_rnd[l])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q <= IDLE;
            idx_q   <= '0;
            in_q    <= '0;
            rate_q  <= '0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            rnd_q   <= 1'b0;
            for (int k = 0; k < N_IN; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            in_q    <= in_d;
            rate_q  <= rate_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            rnd_q   <= rnd_d;
            for (int k = 0; k < N_IN; k++) begin
                w_q[k] <= w_d[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        in_d    = in_q;
        rate_d  = rate_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        rnd_d   = rnd_q;
        w_d     = w_q;

        case (state_q)
            IDLE: begin
                // A host write in the accept cycle lands before the pass reads it.
                if (wr_en) begin
                    w_d[wr_addr] = wr_data;
                end
                if (req_valid) begin
                    in_d    = req_in;
                    rate_d  = req_rate;
                    err_d   = req_error;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    udf_d   = 1'b0;
                    rnd_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    w_d[lane_addr[l]] = lane_w[l];
                end
                ovf_d = ovf_q | (|lane_ovf);
                udf_d = udf_q | (|lane_udf);
                rnd_d = rnd_q | (|lane_rnd);
                idx_d = idx_q + AW'(LANES);
                if (idx_q == AW'(N_IN - LANES)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign rd_data   = w_q[rd_addr];
    assign ovf       = ovf_q;
    assign udf       = udf_q;
    assign rounded   = rnd_q;

endmodule
